mul_seq32: RTL and testbench

Sequential 32x32 integer multiplier producing a full 64-bit product. It is the multiply counterpart to the combinational `intDiv` array divider and sits beside it in the ALU/execute path. It trades latency for area: a radix-2 shift-add datapath iterates 32 times over operand magnitudes, then applies a sign fix. It uses the same `us` signed-select convention as `intDiv`, so both units present identical operand semantics to the control logic.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_seq32_if.sv | 17 +
 rtl/add32.sv | 12 +
 rtl/negate32.sv | 9 +
 rtl/negate64.sv | 9 +
 rtl/mul_seq32.sv | 119 +++++++++++
 tb/tb_mul_seq32.sv | 184 ++++++++++++++++++
 7 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential 32x32 multiplier.
package mul_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ITERS = 32;
   localparam int unsigned CNT_W = $clog2(ITERS);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

   typedef logic [2*WIDTH-1:0] prod_t;

endpackage

// File: rtl/mul_seq32_if.sv
// Request/result bundle between the execute control and the multiplier.
interface mul_seq32_if;
   import mul_pkg::*;

   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             us;
   logic [WIDTH-1:0] P_hi;
   logic [WIDTH-1:0] P_lo;
   logic             busy;
   logic             done;

   modport master (output start, A, B, us, input P_hi, P_lo, busy, done);
   modport slave (input start, A, B, us, output P_hi, P_lo, busy, done);

endinterface

// File: rtl/add32.sv
// 32-bit adder with carry in and carry out.
module add32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};

endmodule

// File: rtl/negate32.sv
// 32-bit two's-complement negate.
module negate32 (
   input  logic [31:0] a_i,
   output logic [31:0] y_o
);

   assign y_o = ~a_i + 32'd1;

endmodule

// File: rtl/negate64.sv
// 64-bit two's-complement negate, used for the final sign fix.
module negate64 (
   input  logic [63:0] a_i,
   output logic [63:0] y_o
);

   assign y_o = ~a_i + 64'd1;

endmodule

// File: rtl/mul_seq32.sv
// Sequential radix-2 shift-add multiplier: magnitudes are multiplied over 32
// iterations, then the product sign is applied in a single fix-up cycle.
module mul_seq32
   import mul_pkg::*;
(
   input logic        clk,
   input logic        rst,
   mul_seq32_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] abs_a_q, abs_a_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic             neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   prod_t            acc_q, acc_d;
   prod_t            prod_q, prod_d;

   logic [WIDTH-1:0] neg_a;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] sum;
   logic             carry;
   prod_t            neg_acc;

   negate32 u_neg_a (
      .a_i (bus.A),
      .y_o (neg_a)
   );

   negate32 u_neg_b (
      .a_i (bus.B),
      .y_o (neg_b)
   );

   add32 u_add (
      .a_i    (acc_q[2*WIDTH-1:WIDTH]),
      .b_i    (abs_a_q),
      .cin_i  (1'b0),
      .sum_o  (sum),
      .cout_o (carry)
   );

   negate64 u_neg_acc (
      .a_i (acc_q),
      .y_o (neg_acc)
   );

   // Next-state and datapath update for the IDLE/RUN/FIX/DONE sequence.
   always_comb begin
      state_d = state_q;
      abs_a_d = abs_a_q;
      mplr_d  = mplr_q;
      neg_d   = neg_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      prod_d  = prod_q;

      unique case (state_q)
         IDLE, DONE: begin
            acc_d = '0;
            cnt_d = '0;
            if (bus.start) begin
               // -2^31 negates to itself, which read unsigned is the right magnitude.
               abs_a_d = (bus.us && bus.A[WIDTH-1]) ? neg_a : bus.A;
               mplr_d  = (bus.us && bus.B[WIDTH-1]) ? neg_b : bus.B;
               neg_d   = bus.us & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // The add carry becomes the new MSB after the right shift.
            if (mplr_q[0]) begin
               acc_d = {carry, sum, acc_q[WIDTH-1:1]};
            end else begin
               acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            mplr_d = mplr_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITERS - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            prod_d  = neg_q ? neg_acc : acc_q;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         abs_a_q <= '0;
         mplr_q  <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         abs_a_q <= abs_a_d;
         mplr_q  <= mplr_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

   assign bus.P_hi = prod_q[2*WIDTH-1:WIDTH];
   assign bus.P_lo = prod_q[WIDTH-1:0];
   assign bus.busy = (state_q == RUN) || (state_q == FIX);
   assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mul_seq32.sv
// Directed self-checking bench for mul_seq32.
module tb_mul_seq32;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;

   mul_seq32_if bus ();

   mul_seq32 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle at a time until done, bounded; lat is the cycle index after T0.
   task automatic wait_done(inout int lat);
      while (bus.done !== 1'b1 && lat < 80) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // One complete operation; returns sampling in the DONE cycle.
   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [63:0] exp);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.us    = s;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      wait_done(lat);
      chk({tag, "_lat"}, 64'(lat), 64'd34);
      chk({tag, "_p"}, {bus.P_hi, bus.P_lo}, exp);
      chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int ndone;

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.us    = 1'b0;
      #1;
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_p", {bus.P_hi, bus.P_lo}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Unsigned small with cycle-exact busy/done checks.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd7;
      bus.B     = 32'd6;
      bus.us    = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         chk($sformatf("small_busy_c%0d", k), {63'd0, bus.busy}, (k <= 33) ? 64'd1 : 64'd0);
         chk($sformatf("small_done_c%0d", k), {63'd0, bus.done}, (k == 34) ? 64'd1 : 64'd0);
      end
      chk("small_p", {bus.P_hi, bus.P_lo}, 64'h0000_0000_0000_002A);

      op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      op("smax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
      op("mix1", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      op("mix2", 32'd5, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      op("min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      op("min1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000);
      op("umin1", 32'h8000_0000, 32'd1, 1'b0, 64'h0000_0000_8000_0000);
      op("u2", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
      op("s2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      op("zneg", 32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0);

      // Start while busy is ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd3;
      bus.B     = 32'd5;
      bus.us    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      repeat (9) begin
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b1;
      bus.A     = 32'd100;
      bus.B     = 32'd100;
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      wait_done(lat);
      chk("ign_lat", 64'(lat), 64'd34);
      chk("ign_p", {bus.P_hi, bus.P_lo}, 64'd15);

      // Back-to-back by holding start through DONE.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd2;
      bus.B     = 32'd3;
      bus.us    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      bus.A = 32'd4;
      bus.B = 32'd5;
      wait_done(lat);
      chk("b2b_lat1", 64'(lat), 64'd34);
      chk("b2b_p1", {bus.P_hi, bus.P_lo}, 64'd6);
      @(negedge clk);
      lat++;
      chk("b2b_busy35", {63'd0, bus.busy}, 64'd1);
      chk("b2b_done35", {63'd0, bus.done}, 64'd0);
      wait_done(lat);
      chk("b2b_lat2", 64'(lat), 64'd68);
      chk("b2b_p2", {bus.P_hi, bus.P_lo}, 64'd20);
      bus.start = 1'b0;
      @(negedge clk);
      chk("b2b_idle_busy", {63'd0, bus.busy}, 64'd0);
      chk("b2b_idle_done", {63'd0, bus.done}, 64'd0);
      chk("b2b_hold_p", {bus.P_hi, bus.P_lo}, 64'd20);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 32'd9;
      bus.B     = 32'd9;
      bus.us    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_busy", {63'd0, bus.busy}, 64'd0);
      chk("mrst_done", {63'd0, bus.done}, 64'd0);
      chk("mrst_p", {bus.P_hi, bus.P_lo}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("mrst_nodone", 64'(ndone), 64'd0);
      op("post_rst", 32'd9, 32'd9, 1'b0, 64'd81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
